bus_arbiter_2to1: RTL and testbench

Shares one Wishbone-classic memory port between a core's instruction bus (core_*) and data bus (data_mem_*). It is used when a core has two buses but the board or Controller offers a single memory. The block sits between the core wrapper and the Controller memory port. It arbitrates round-robin, one transfer per grant, and has a per-transfer ack timeout that returns an error to the stalled requester.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/bus_arbiter_2to1.sv | 138 +++++++++++++
 tb/tb_bus_arbiter_2to1.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and round-robin pick function for the 2:1 Wishbone-classic arbiter.
package bus_arbiter_pkg;

   // State values double as the grant_o encoding
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } arb_state_t;

   localparam logic [1:0] GNT_NONE  = 2'b00;
   localparam logic [1:0] GNT_INSTR = 2'b01;
   localparam logic [1:0] GNT_DATA  = 2'b10;

   function automatic arb_state_t rr_pick(input logic req_i, input logic req_d,
                                          input logic [1:0] last_grant);
      if (req_i && req_d)
         return (last_grant == GNT_INSTR) ? GNT_D : GNT_I;
      else if (req_i)
         return GNT_I;
      else if (req_d)
         return GNT_D;
      else
         return IDLE;
   endfunction

endpackage

// File: rtl/bus_arbiter_2to1.sv
// Round-robin 2:1 arbiter sharing one Wishbone-classic memory port between an
// instruction bus and a data bus; one transfer per grant, optional ack timeout.
module bus_arbiter_2to1
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    core_cyc_i,
   input  logic                    core_stb_i,
   input  logic                    core_we_i,
   input  logic [DATA_WIDTH/8-1:0] core_wstrb_i,
   input  logic [ADDR_WIDTH-1:0]   core_addr_i,
   input  logic [DATA_WIDTH-1:0]   core_data_i,
   output logic [DATA_WIDTH-1:0]   core_data_o,
   output logic                    core_ack_o,
   output logic                    core_err_o,
   input  logic                    data_mem_cyc_i,
   input  logic                    data_mem_stb_i,
   input  logic                    data_mem_we_i,
   input  logic [DATA_WIDTH/8-1:0] data_mem_wstrb_i,
   input  logic [ADDR_WIDTH-1:0]   data_mem_addr_i,
   input  logic [DATA_WIDTH-1:0]   data_mem_data_i,
   output logic [DATA_WIDTH-1:0]   data_mem_data_o,
   output logic                    data_mem_ack_o,
   output logic                    data_mem_err_o,
   output logic                    mem_cyc_o,
   output logic                    mem_stb_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_data_o,
   input  logic [DATA_WIDTH-1:0]   mem_data_i,
   input  logic                    mem_ack_i,
   output logic [1:0]              grant_o
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_t       state, state_nxt;
   logic [1:0]       last_grant, last_grant_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic req_i, req_d, own_i, own_d, own_cyc, own_stb, timeout_hit;

   assign req_i = core_cyc_i & core_stb_i;
   assign req_d = data_mem_cyc_i & data_mem_stb_i;
   assign own_i = (state == GNT_I);
   assign own_d = (state == GNT_D);

   assign own_cyc = (own_i & core_cyc_i) | (own_d & data_mem_cyc_i);
   assign own_stb = (own_i & core_stb_i) | (own_d & data_mem_stb_i);

   // Ack in the final cycle takes priority over the timeout
   assign timeout_hit = TO_EN & (own_i | own_d) & ~mem_ack_i & (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GNT_DATA;
         cnt        <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         cnt        <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      case (state)
         IDLE: begin
            state_nxt = rr_pick(req_i, req_d, last_grant);
            cnt_nxt   = '0;
         end
         GNT_I, GNT_D: begin
            if (mem_ack_i || !own_cyc || timeout_hit) begin
               state_nxt      = IDLE;
               last_grant_nxt = own_i ? GNT_INSTR : GNT_DATA;
               cnt_nxt        = '0;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      mem_cyc_o       = 1'b0;
      mem_stb_o       = 1'b0;
      mem_we_o        = 1'b0;
      mem_wstrb_o     = '0;
      mem_addr_o      = '0;
      mem_data_o      = '0;
      core_ack_o      = 1'b0;
      core_err_o      = 1'b0;
      data_mem_ack_o  = 1'b0;
      data_mem_err_o  = 1'b0;
      core_data_o     = '0;
      data_mem_data_o = '0;
      if (own_i) begin
         mem_we_o    = core_we_i;
         mem_wstrb_o = core_wstrb_i;
         mem_addr_o  = core_addr_i;
         mem_data_o  = core_data_i;
         core_ack_o  = mem_ack_i;
         core_err_o  = timeout_hit;
      end else if (own_d) begin
         mem_we_o       = data_mem_we_i;
         mem_wstrb_o    = data_mem_wstrb_i;
         mem_addr_o     = data_mem_addr_i;
         mem_data_o     = data_mem_data_i;
         data_mem_ack_o = mem_ack_i;
         data_mem_err_o = timeout_hit;
      end
      if (own_i || own_d) begin
         mem_cyc_o       = own_cyc & ~timeout_hit;
         mem_stb_o       = own_cyc & own_stb & ~timeout_hit;
         core_data_o     = mem_data_i;
         data_mem_data_o = mem_data_i;
      end
   end

   assign grant_o = state;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle checked
// against a transaction-level owner/age reference model.
module tb_bus_arbiter_2to1;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          core_cyc, core_stb, core_we;
   logic [SW-1:0] core_wstrb;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          dm_cyc, dm_stb, dm_we;
   logic [SW-1:0] dm_wstrb;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   logic [DW-1:0] core_data_o, data_mem_data_o, mem_data_o;
   logic          core_ack_o, core_err_o, data_mem_ack_o, data_mem_err_o;
   logic          mem_cyc_o, mem_stb_o, mem_we_o;
   logic [SW-1:0] mem_wstrb_o;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    grant_o;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the port, cycles spent in grant, last served (1=I, 2=D)
   int m_owner, m_age, m_last;

   logic [1:0]    obs_grant;
   logic          obs_mem_cyc, obs_mem_stb, obs_mem_we;
   logic [SW-1:0] obs_mem_wstrb;
   logic [AW-1:0] obs_mem_addr;
   logic [DW-1:0] obs_mem_wdata, obs_core_rd, obs_data_rd;
   logic          obs_core_ack, obs_core_err, obs_data_ack, obs_data_err;

   bus_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_cyc_i(core_cyc), .core_stb_i(core_stb), .core_we_i(core_we),
      .core_wstrb_i(core_wstrb), .core_addr_i(core_addr), .core_data_i(core_wdata),
      .core_data_o(core_data_o), .core_ack_o(core_ack_o), .core_err_o(core_err_o),
      .data_mem_cyc_i(dm_cyc), .data_mem_stb_i(dm_stb), .data_mem_we_i(dm_we),
      .data_mem_wstrb_i(dm_wstrb), .data_mem_addr_i(dm_addr), .data_mem_data_i(dm_wdata),
      .data_mem_data_o(data_mem_data_o), .data_mem_ack_o(data_mem_ack_o),
      .data_mem_err_o(data_mem_err_o),
      .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      core_cyc = 0; core_stb = 0; core_we = 0; core_wstrb = '0; core_addr = '0; core_wdata = '0;
      dm_cyc = 0; dm_stb = 0; dm_we = 0; dm_wstrb = '0; dm_addr = '0; dm_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
   endtask

   // One clock cycle: sample at negedge, compare to the model, advance the model.
   task automatic step();
      logic [70:0]   exp_mem, act_mem;
      logic [33:0]   exp_c, act_c, exp_d, act_d;
      logic [1:0]    exp_g;
      logic          tmo, o_cyc, o_stb, o_we;
      logic [SW-1:0] o_ws;
      logic [AW-1:0] o_a;
      logic [DW-1:0] o_d;
      @(negedge clk);
      obs_grant = grant_o; obs_mem_cyc = mem_cyc_o; obs_mem_stb = mem_stb_o; obs_mem_we = mem_we_o;
      obs_mem_wstrb = mem_wstrb_o; obs_mem_addr = mem_addr_o; obs_mem_wdata = mem_data_o;
      obs_core_rd = core_data_o; obs_data_rd = data_mem_data_o;
      obs_core_ack = core_ack_o; obs_core_err = core_err_o;
      obs_data_ack = data_mem_ack_o; obs_data_err = data_mem_err_o;

      exp_mem = '0; exp_c = '0; exp_d = '0; exp_g = 2'b00; tmo = 0;
      o_cyc = 0; o_stb = 0; o_we = 0; o_ws = '0; o_a = '0; o_d = '0;
      if (rst_n && m_owner != 0) begin
         if (m_owner == 1) {o_cyc, o_stb, o_we, o_ws, o_a, o_d} = {core_cyc, core_stb, core_we, core_wstrb, core_addr, core_wdata};
         else              {o_cyc, o_stb, o_we, o_ws, o_a, o_d} = {dm_cyc, dm_stb, dm_we, dm_wstrb, dm_addr, dm_wdata};
         tmo = (m_age == TO - 1) && !mem_ack;
         exp_mem = {o_cyc && !tmo, o_cyc && o_stb && !tmo, o_we, o_ws, o_a, o_d};
         if (m_owner == 1) begin
            exp_c = {mem_ack, tmo, mem_rdata};
            exp_d = {1'b0, 1'b0, mem_rdata};
         end else begin
            exp_c = {1'b0, 1'b0, mem_rdata};
            exp_d = {mem_ack, tmo, mem_rdata};
         end
         exp_g = 2'(m_owner);
      end
      act_mem = {mem_cyc_o, mem_stb_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_data_o};
      act_c   = {core_ack_o, core_err_o, core_data_o};
      act_d   = {data_mem_ack_o, data_mem_err_o, data_mem_data_o};

      checks++;
      if (act_mem !== exp_mem) begin errors++; $display("FAIL mem_port t=%0t: got %h want %h", $time, act_mem, exp_mem); end
      checks++;
      if (act_c !== exp_c) begin errors++; $display("FAIL core_resp t=%0t: got %h want %h", $time, act_c, exp_c); end
      checks++;
      if (act_d !== exp_d) begin errors++; $display("FAIL data_resp t=%0t: got %h want %h", $time, act_d, exp_d); end
      checks++;
      if (grant_o !== exp_g) begin errors++; $display("FAIL grant t=%0t: got %b want %b", $time, grant_o, exp_g); end

      if (!rst_n) begin
         m_owner = 0; m_age = 0; m_last = 2;
      end else if (m_owner == 0) begin
         if ((core_cyc && core_stb) && (dm_cyc && dm_stb)) m_owner = (m_last == 1) ? 2 : 1;
         else if (core_cyc && core_stb)                     m_owner = 1;
         else if (dm_cyc && dm_stb)                         m_owner = 2;
         m_age = 0;
      end else if (mem_ack || !o_cyc || tmo) begin
         m_last = m_owner; m_owner = 0; m_age = 0;
      end else begin
         m_age++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      core_cyc = 1; core_stb = 1; dm_cyc = 1; dm_stb = 1; mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
      #2;
      checks++;
      if ({mem_cyc_o, mem_stb_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_data_o, grant_o,
           core_ack_o, core_err_o, core_data_o, data_mem_ack_o, data_mem_err_o, data_mem_data_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
      end
      step(); step();
      clear_inputs();
      rst_n = 1;
      step();
   endtask

   task automatic test_single_read();
      clear_inputs();
      core_cyc = 1; core_stb = 1; core_addr = 32'h100;
      step();
      checks++;
      if (obs_mem_stb !== 1'b0) begin errors++; $display("FAIL read_stb_early: got %b want 0", obs_mem_stb); end
      step();
      checks++;
      if ({obs_mem_stb, obs_mem_addr} !== {1'b1, 32'h100}) begin
         errors++; $display("FAIL read_stb_latency: got stb=%b addr=%h want stb=1 addr=100", obs_mem_stb, obs_mem_addr);
      end
      step();
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      step();
      checks++;
      if ({obs_core_ack, obs_core_rd, obs_data_ack} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
         errors++; $display("FAIL read_ack: got ack=%b data=%h dack=%b want 1 deadbeef 0", obs_core_ack, obs_core_rd, obs_data_ack);
      end
      clear_inputs();
      step();
      checks++;
      if (obs_grant !== 2'b00) begin errors++; $display("FAIL read_grant_idle: got %b want 00", obs_grant); end
   endtask

   task automatic test_tie_after_reset();
      clear_inputs();
      rst_n = 0; step(); rst_n = 1;
      core_cyc = 1; core_stb = 1; core_addr = 32'h0;
      dm_cyc = 1; dm_stb = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_wstrb = 4'hF;
      step();
      mem_ack = 1; mem_rdata = 32'h0BADF00D;
      step();
      checks++;
      if ({obs_grant, obs_core_ack} !== {2'b01, 1'b1}) begin
         errors++; $display("FAIL tie_first: got grant=%b ack=%b want 01 1", obs_grant, obs_core_ack);
      end
      core_cyc = 0; core_stb = 0; mem_ack = 0;
      step();
      checks++;
      if (obs_grant !== 2'b00) begin errors++; $display("FAIL tie_gap: got %b want 00", obs_grant); end
      mem_ack = 1;
      step();
      checks++;
      if ({obs_grant, obs_mem_we, obs_mem_wstrb, obs_mem_addr, obs_mem_wdata, obs_data_ack} !==
          {2'b10, 1'b1, 4'hF, 32'h2000, 32'h12345678, 1'b1}) begin
         errors++; $display("FAIL tie_write: got g=%b we=%b ws=%h a=%h d=%h ack=%b", obs_grant, obs_mem_we,
                            obs_mem_wstrb, obs_mem_addr, obs_mem_wdata, obs_data_ack);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      logic [1:0] want;
      clear_inputs();
      core_cyc = 1; core_stb = 1; dm_cyc = 1; dm_stb = 1;
      for (int i = 0; i < 12; i++) begin
         mem_ack = (i % 2 == 1); mem_rdata = $urandom;
         core_addr = $urandom; dm_addr = $urandom;
         step();
         if (i % 2 == 1) begin
            want = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({obs_grant, obs_core_ack, obs_data_ack} !== {want, want == 2'b01, want == 2'b10}) begin
               errors++; $display("FAIL alternate[%0d]: got g=%b ca=%b da=%b want g=%b", i / 2, obs_grant,
                                  obs_core_ack, obs_data_ack, want);
            end
         end
      end
      clear_inputs();
      step();
   endtask

   task automatic test_timeout();
      int err_cnt, err_idx;
      logic err_cyc;
      clear_inputs();
      dm_cyc = 1; dm_stb = 1; dm_addr = 32'h3000;
      err_cnt = 0; err_idx = -1; err_cyc = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         if (i >= 1) begin core_cyc = 1; core_stb = 1; core_addr = 32'h44; end
         mem_ack = (i == 10); mem_rdata = 32'hCAFE0001;
         step();
         if (obs_data_err) begin err_cnt++; err_idx = i; err_cyc = obs_mem_cyc; end
         if (i == 9) begin
            checks++;
            if (obs_grant !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %b want 00", obs_grant); end
         end
         if (i == 10) begin
            checks++;
            if ({obs_grant, obs_core_ack} !== {2'b01, 1'b1}) begin
               errors++; $display("FAIL timeout_next: got g=%b ack=%b want 01 1", obs_grant, obs_core_ack);
            end
         end
      end
      checks++;
      if (err_cnt != 1 || err_idx != 8 || err_cyc !== 1'b0) begin
         errors++; $display("FAIL timeout_err: got count=%0d idx=%0d cyc=%b want 1 8 0", err_cnt, err_idx, err_cyc);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_abort();
      clear_inputs();
      core_cyc = 1; core_stb = 1; core_addr = 32'h500;
      step();
      step();
      checks++;
      if (obs_grant !== 2'b01) begin errors++; $display("FAIL abort_grant: got %b want 01", obs_grant); end
      core_cyc = 0;
      step();
      checks++;
      if (obs_mem_cyc !== 1'b0) begin errors++; $display("FAIL abort_cyc: got %b want 0", obs_mem_cyc); end
      core_stb = 0; mem_ack = 1; mem_rdata = 32'h77777777;
      step();
      checks++;
      if ({obs_core_ack, obs_data_ack, obs_grant} !== 4'b0000) begin
         errors++; $display("FAIL abort_stray_ack: got ca=%b da=%b g=%b want 0 0 00", obs_core_ack, obs_data_ack, obs_grant);
      end
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      core_cyc = 1; core_stb = 1; core_addr = 32'h600;
      step();
      step();
      checks++;
      if (mem_cyc_o !== 1'b1) begin errors++; $display("FAIL midxfer_cyc: got %b want 1", mem_cyc_o); end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({mem_cyc_o, mem_stb_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_data_o, grant_o,
           core_ack_o, core_err_o, core_data_o, data_mem_ack_o, data_mem_err_o, data_mem_data_o} !== '0) begin
         errors++; $display("FAIL async_reset: outputs nonzero %b %b %b", mem_cyc_o, grant_o, core_ack_o);
      end
      m_owner = 0; m_age = 0; m_last = 2;
      step();
      rst_n = 1;
      dm_cyc = 1; dm_stb = 1;
      step();
      mem_ack = 1;
      step();
      checks++;
      if (obs_grant !== 2'b01) begin errors++; $display("FAIL reset_tie: got %b want 01", obs_grant); end
      clear_inputs();
      step();
   endtask

   task automatic test_random();
      int p_req, p_ack;
      for (int ph = 0; ph < 3; ph++) begin
         p_req = (ph == 0) ? 2 : (ph == 1) ? 8 : 4;
         p_ack = (ph == 0) ? 3 : (ph == 1) ? 12 : 2;
         for (int i = 0; i < 600; i++) begin
            core_cyc = ($urandom % p_req) != 0; core_stb = ($urandom % 4) != 0; core_we = $urandom;
            core_wstrb = SW'($urandom); core_addr = $urandom; core_wdata = $urandom;
            dm_cyc = ($urandom % p_req) != 0; dm_stb = ($urandom % 4) != 0; dm_we = $urandom;
            dm_wstrb = SW'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
            mem_ack = ($urandom % p_ack) == 0; mem_rdata = $urandom;
            step();
         end
      end
      clear_inputs();
      step();
   endtask

   initial begin
      m_owner = 0; m_age = 0; m_last = 2;
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_single_read();
      test_tie_after_reset();
      test_back_to_back();
      test_timeout();
      test_abort();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
